param_register_file: RTL
========================

# param_register_file

Parametrised successor to the pipeline's integer register file. It provides NUM_READ registered read ports, one write port, write-to-read bypass and an optional hardwired zero register. Array initialisation is sequenced by a one-entry-per-cycle sweep after reset or on request, so reset does not fan out to the storage array. It sits in the decode stage of the RISC-V pipeline, and its debug port feeds the bring-up/inspection logic.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries
- NUM_READ, 2, number of pipeline read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes
- INIT_INDEX, 1, 1 = sweep loads entry i with value i; 0 = sweep loads 0

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- read_address  in  NUM_READ*ADDR_WIDTH  port k address at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- data_out  out  NUM_READ*DATA_WIDTH  port k registered read data, same packing
- write_enable  in  1  write strobe
- write_address  in  ADDR_WIDTH  write target
- write_data_in  in  DATA_WIDTH  write data
- clear_request  in  1  starts a re-initialisation sweep (sampled in IDLE only)
- ready  out  1  1 = array valid and writes accepted
- read_address_debug  in  ADDR_WIDTH  debug read address
- data_out_debug  out  DATA_WIDTH  registered raw array contents, no bypass

## Operation
- FSM states: INIT, IDLE. Sweep counter is ADDR_WIDTH bits.
- Reset (reset_n=0): state=INIT, counter=0, ready=0, every data_out lane=0, data_out_debug=0. Array contents are not reset.
- INIT: each edge writes r[counter] = (INIT_INDEX ? counter : 0), with entry 0 always 0 when ZERO_REG=1. Counter then increments.
  - The write at counter=DEPTH-1 moves the FSM to IDLE and sets ready=1.
- IDLE with clear_request=1: go to INIT, counter=0, ready=0. A write presented in the same cycle is discarded.
- clear_request is ignored while in INIT; the sweep does not restart.
- Writes are applied only when ready=1, write_enable=1, and (write_address!=0 or ZERO_REG=0). Writes while ready=0 are dropped silently; upstream must stall on ready.
- Read port k in IDLE: data_out[k] <= value at read_address[k].
  - Bypass: if a write is being applied this cycle to the same address, load write_data_in instead of the stale array value.
  - With ZERO_REG=1, address 0 always yields 0, including under bypass.
- Read ports while ready=0: data_out lanes load 0.
- Debug port: data_out_debug <= r[read_address_debug] every edge in any state. Reads the pre-write array value, with no bypass and no zero masking (returns the stored r[0]).
- Multiple read ports may present the same address; each receives identical data.

## Timing
- Read latency: 1 cycle. Address presented before edge N gives data valid after edge N.
- Write-to-read: a read issued in the same cycle as the write to that address returns the new value after the same edge, via bypass.
- Sweep: ready rises at the DEPTH-th rising edge after reset_n deasserts (32 edges by default). It also rises DEPTH edges after the edge that sampled clear_request.
- Asserting reset_n=0 mid-sweep or mid-operation: outputs go to reset values immediately (asynchronous); the sweep restarts from entry 0 after release.
- Debug read latency: 1 cycle. During INIT, data_out_debug may show partially swept contents.

## Structure
- Package rf_pkg:
  - state enum {RF_INIT, RF_IDLE}
  - function rf_init_value(index, INIT_INDEX, ZERO_REG)
  - port-packing slice helpers
- Sub-module rf_read_port: one registered read lane.
  - Inputs: array value, address, write bypass inputs, ready.
  - Handles bypass and zero masking.
  - Instantiated NUM_READ times in a generate loop.
- Storage array, FSM, sweep counter and debug lane live in the top module.

## Test plan
- Reset release, defaults: ready=0 for edges 1..31 and 1 after edge 32. Then read_address {3,31} -> data_out {3,31}. Debug address 0 -> 0.
- Write 0xDEADBEEF to 5 while port 0 reads 5 in the same cycle -> data_out[0]=0xDEADBEEF after that edge. Debug read of 5 in that same cycle -> 5 (old value); next cycle -> 0xDEADBEEF.
- ZERO_REG=1: write 0x1234 to 0, then read 0 on both ports, including same-cycle bypass -> 0 on both.
- clear_request asserted together with a write of 0xAA to 7 -> write dropped, ready=0 for 32 edges, then read 7 -> 7. Writes issued during the sweep leave no effect.
- reset_n pulsed low at sweep edge 10 -> data_out and ready go to 0 asynchronously. Ready returns exactly 32 edges after release.
- NUM_READ=4, INIT_INDEX=0, DATA_WIDTH=64: after sweep, all entries read 0. A 64-bit write to 9 read on all four ports -> identical 64-bit value on every lane.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared declarations for the parametrised register file.
//   rf_state_e    - FSM states for the initialisation sweep
//   rf_init_value - value an entry receives during the sweep
//   rf_lane_lsb/msb - bit positions of lane k inside a packed port bus
package rf_pkg;

   typedef enum logic {
      RF_INIT = 1'b0,
      RF_IDLE = 1'b1
   } rf_state_e;

   // Largest number of pipeline read ports the block is built for.
   localparam int RF_MAX_READ = 4;

   // Value written into entry 'index' by the sweep. Returned as 32 bits and
   // resized by the caller, since package functions cannot see DATA_WIDTH.
   function automatic logic [31:0] rf_init_value(input logic [31:0] index,
                                                 input bit          init_index,
                                                 input bit          zero_reg);
      if (!init_index) return 32'd0;
      if (zero_reg && (index == 32'd0)) return 32'd0;
      return index;
   endfunction

   function automatic int rf_lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

   function automatic int rf_lane_msb(input int lane, input int width);
      return (lane * width) + width - 1;
   endfunction

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one registered read lane of the register file.
//   clock, reset_n  - clock and asynchronous active-low reset
//   array_value     - raw array contents at 'address'
//   address         - lane read address
//   write_apply     - a write is committed to the array this cycle
//   write_address   - target of that write
//   write_data      - data of that write (bypass source)
//   ready           - array is valid; lane loads 0 otherwise
//   data_out        - registered lane data
module rf_read_port #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] array_value,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  write_apply,
   input  logic [ADDR_WIDTH-1:0] write_address,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  ready,
   output logic [DATA_WIDTH-1:0] data_out
);

   logic [DATA_WIDTH-1:0] lane_next;

   // Zero masking takes priority over bypass, so entry 0 reads 0 even when
   // an (ignored) write targets it in the same cycle.
   always_comb begin
      lane_next = array_value;
      if (!ready) begin
         lane_next = '0;
      end else if ((ZERO_REG != 0) && (address == '0)) begin
         lane_next = '0;
      end else if (write_apply && (address == write_address)) begin
         lane_next = write_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= '0;
      end else begin
         data_out <= lane_next;
      end
   end

endmodule

// File: rtl/param_register_file.sv
// param_register_file: decode-stage integer register file with NUM_READ
// registered read ports, one write port, write-to-read bypass, optional
// hardwired zero entry and a sweep-based array initialisation.
//   clock, reset_n      - clock and asynchronous active-low reset
//   read_address        - packed read addresses, lane k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   data_out            - packed registered read data, same lane packing
//   write_enable/_address/write_data_in - write port
//   clear_request       - restart the initialisation sweep (honoured in IDLE)
//   ready               - array valid, writes accepted
//   read_address_debug  - debug read address
//   data_out_debug      - registered raw array contents (no bypass, no masking)
module param_register_file
   import rf_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_READ   = 2,
   parameter int ZERO_REG   = 1,
   parameter int INIT_INDEX = 1
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] read_address,
   output logic [NUM_READ*DATA_WIDTH-1:0] data_out,
   input  logic                           write_enable,
   input  logic [ADDR_WIDTH-1:0]          write_address,
   input  logic [DATA_WIDTH-1:0]          write_data_in,
   input  logic                           clear_request,
   output logic                           ready,
   input  logic [ADDR_WIDTH-1:0]          read_address_debug,
   output logic [DATA_WIDTH-1:0]          data_out_debug
);

   localparam int                    DEPTH      = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = ADDR_WIDTH'(DEPTH - 1);
   localparam bit                    HAS_ZERO   = (ZERO_REG != 0);
   localparam bit                    SWEEP_INDEX = (INIT_INDEX != 0);

   if ((NUM_READ < 1) || (NUM_READ > RF_MAX_READ)) begin : g_bad_num_read
      $error("param_register_file: NUM_READ must be 1..%0d", RF_MAX_READ);
   end

   // Storage array: deliberately not reset; the sweep initialises it.
   logic [DATA_WIDTH-1:0] r [DEPTH];

   rf_state_e             state;
   rf_state_e             state_next;
   logic [ADDR_WIDTH-1:0] counter;
   logic [DATA_WIDTH-1:0] init_value;
   logic                  write_apply;

   // FSM: state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= RF_INIT;
      end else begin
         state <= state_next;
      end
   end

   // FSM: next state. clear_request is only looked at in IDLE, so a request
   // during the sweep neither restarts nor extends it.
   always_comb begin
      state_next = state;
      case (state)
         RF_INIT: if (counter == LAST_ENTRY) state_next = RF_IDLE;
         RF_IDLE: if (clear_request)         state_next = RF_INIT;
         default: state_next = RF_INIT;
      endcase
   end

   // FSM: outputs
   always_comb begin
      ready = (state == RF_IDLE);
   end

   // Sweep counter: advances once per edge in INIT and wraps to 0 on the
   // final entry; re-armed explicitly when a clear is accepted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         counter <= '0;
      end else if (state == RF_INIT) begin
         counter <= counter + 1'b1;
      end else if (clear_request) begin
         counter <= '0;
      end
   end

   always_comb begin
      init_value = DATA_WIDTH'(rf_init_value(32'(counter), SWEEP_INDEX, HAS_ZERO));
   end

   // A write in the cycle that accepts a clear is discarded, as is any write
   // to entry 0 when it is hardwired.
   always_comb begin
      write_apply = ready && write_enable && !clear_request &&
                    (!HAS_ZERO || (write_address != '0));
   end

   always_ff @(posedge clock) begin
      if (state == RF_INIT) begin
         r[counter] <= init_value;
      end else if (write_apply) begin
         r[write_address] <= write_data_in;
      end
   end

   // Debug lane: raw pre-write contents, live in every state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_out_debug <= '0;
      end else begin
         data_out_debug <= r[read_address_debug];
      end
   end

   for (genvar k = 0; k < NUM_READ; k++) begin : g_read
      logic [ADDR_WIDTH-1:0] lane_address;

      assign lane_address = read_address[rf_lane_msb(k, ADDR_WIDTH):rf_lane_lsb(k, ADDR_WIDTH)];

      rf_read_port #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH),
         .ZERO_REG   (ZERO_REG)
      ) u_read_port (
         .clock         (clock),
         .reset_n       (reset_n),
         .array_value   (r[lane_address]),
         .address       (lane_address),
         .write_apply   (write_apply),
         .write_address (write_address),
         .write_data    (write_data_in),
         .ready         (ready),
         .data_out      (data_out[rf_lane_msb(k, DATA_WIDTH):rf_lane_lsb(k, DATA_WIDTH)])
      );
   end

endmodule
